// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, plus sign fix.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mb;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           sa;
  logic           sb;
  logic           dz;

  logic           sgn;
  logic [W-1:0]   amag;
  logic [W-1:0]   bmag;

  always_comb begin
    sgn  = op[0] & ~op[2];
    amag = (sgn && A[W-1]) ? -A : A;
    bmag = (sgn && B[W-1]) ? -B : B;
  end

  logic [W:0]     msum;
  logic [W:0]     dsh;
  logic [W:0]     ddif;
  logic [2*W-1:0] acc_step;

  // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps
  // {partial product, remaining multiplier bits}.
  always_comb begin
    msum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mb : {W{1'b0}})};
    dsh  = acc[2*W-1:W-1];
    ddif = dsh - {1'b0, mb};
    if (!is_div)
      acc_step = {msum, acc[W-1:1]};
    else if (ddif[W])
      acc_step = {dsh[W-1:0], acc[W-2:0], 1'b0};
    else
      acc_step = {ddif[W-1:0], acc[W-2:0], 1'b1};
  end

  logic [2*W-1:0] acc_neg;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  always_comb begin
    acc_neg = -acc;
    fix_hi  = acc[2*W-1:W];
    fix_lo  = acc[W-1:0];
    if (dz) begin
      fix_hi = mb;
      fix_lo = {W{1'b1}};
    end else if (is_div) begin
      if (sa ^ sb)
        fix_lo = -acc[W-1:0];
      if (sa)
        fix_hi = -acc[2*W-1:W];
    end else if (sa ^ sb) begin
      fix_hi = acc_neg[2*W-1:W];
      fix_lo = acc_neg[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mb     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            unique case (1'b1)
              !op[2]: begin
                state  <= CALC;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= op[1];
                sa     <= sgn & A[W-1];
                sb     <= sgn & B[W-1];
                dz     <= op[1] & (B == '0);
                acc    <= {{W{1'b0}}, (op[1] ? amag : bmag)};
                // On divide-by-zero mb carries the raw dividend for HI.
                if (!op[1])
                  mb <= amag;
                else if (B == '0)
                  mb <= A;
                else
                  mb <= bmag;
              end
              (op[2:1] == 2'b10): begin
                if (op[0])
                  lo <= A;
                else
                  hi <= A;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1))
            state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random model, corners.
// Results are scoreboarded at each done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({"hi[", e.tag, "]"}, hi, e.hi);
        chk({"lo[", e.tag, "]"}, lo, e.lo);
      end
    end
  end

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sp;
    int     q;
    int     r;
    case (o)
      3'd0: return {32'b0, a} * {32'b0, b};
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Called between edges with the DUT in IDLE or DONE; returns at the
  // negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input string tag);
    int          n;
    int          bc;
    bit          seen;
    logic [31:0] ph;
    logic [31:0] pl;
    ph = hi;
    pl = lo;
    sbq.push_back('{eh, el, tag});
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'b111;
    A = $urandom;
    B = $urandom;
    n = 0;
    bc = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (n == 33) begin
        chk({"hold_hi[", tag, "]"}, hi, ph);
        chk({"hold_lo[", tag, "]"}, lo, pl);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout[%s]: got no done in %0d cycles expected 34", tag, n);
      void'(sbq.pop_back());
    end else begin
      chk({"latency[", tag, "]"}, 32'(n), 32'd34);
      chk({"busy_cycles[", tag, "]"}, 32'(bc), 32'd33);
    end
  endtask

  task automatic pulse(input logic [2:0] o, input logic [31:0] a);
    op = o;
    A = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    bit          seen;

    vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "MULTU max"};
    vt[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "MULT -3*5"};
    vt[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2"};
    vt[3]  = '{3'b010, 32'd100,      32'd7,        32'd2,        32'd14,       "DIVU 100/7"};
    vt[4]  = '{3'b011, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "DIV by 0"};
    vt[5]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "DIV ovf"};
    vt[6]  = '{3'b001, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "MULT 7*-6"};
    vt[7]  = '{3'b010, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, "DIVU max/10"};
    vt[8]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "DIV 7/-2"};
    vt[9]  = '{3'b011, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "DIV -7/-2"};
    vt[10] = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "MULTU 2^32"};
    vt[11] = '{3'b011, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "DIV -8/0"};

    reset = 1'b1;
    start = 1'b0;
    op = 3'b000;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;

    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].tag);

    @(negedge clk);
    pulse(3'b100, 32'hDEADBEEF);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'hFFFFFFFF);
    chk("mthi_busy", 32'(busy), 32'h0);
    chk("mthi_done", 32'(done), 32'h0);
    pulse(3'b101, 32'hCAFEF00D);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    pulse(3'b110, 32'h00000001);
    chk("nop_hi", hi, 32'hDEADBEEF);
    chk("nop_lo", lo, 32'hCAFEF00D);
    chk("nop_busy", 32'(busy), 32'h0);

    op = 3'b011;
    A = 32'h00001234;
    B = 32'h00000011;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    run_op(3'b000, 32'd7, 32'd9, 32'd0, 32'd63, "MULTU after reset");

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) rb = 32'h0;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], "random");
    end

    sbq.push_back('{32'h0, 32'd15, "MULT ignore 2nd"});
    op = 3'b001;
    A = 32'd3;
    B = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = 3'b000;
    A = 32'hFFFFFFFF;
    B = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 5;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout[ignore 2nd]: got no done expected 34");
      void'(sbq.pop_back());
    end else begin
      chk("ignore_latency", 32'(n), 32'd34);
    end
    @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
